// File: rtl/reg_pipe_vld_rdy.sv
// Valid/ready register pipe of DEPTH stages; optional occupancy counter under REG_PIPE_CNT_EN.
// Latency DEPTH cycles from i_vld presented to o_vld when unstalled; full throughput of one item per cycle.
// Backpressure collapses bubbles: empty stages keep loading while i_rdy=0; i_flush empties every stage.
module reg_pipe_vld_rdy #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
    localparam int                   CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [DATA_WIDTH-1:0] o_data
`ifdef REG_PIPE_CNT_EN
    ,
    output logic [CNT_W-1:0]      o_cnt
`endif
);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $fatal(1, "reg_pipe_vld_rdy: DEPTH must be in 1..16");
    end

    localparam logic [DEPTH-1:0] ALL_VLD = '1;

    logic [DEPTH-1:0]      r_vld;
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      w_rdy;
    logic [DEPTH-1:0]      w_in_vld;
    logic [DATA_WIDTH-1:0] w_in_data [DEPTH];

    // Stage k is ready unless it and every stage in front of it are full and the consumer stalls.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        assign w_rdy[k] = i_rdy | ((r_vld >> k) != (ALL_VLD >> k));
        if (k == 0) begin : g_head
            assign w_in_vld[k]  = i_vld;
            assign w_in_data[k] = i_data;
        end else begin : g_body
            assign w_in_vld[k]  = r_vld[k-1];
            assign w_in_data[k] = r_data[k-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= RST_VAL;
            end
        end else if (i_flush) begin
            r_vld <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_rdy[k]) begin
                    r_vld[k] <= w_in_vld[k];
                    if (w_in_vld[k]) begin
                        r_data[k] <= w_in_data[k];
                    end
                end
            end
        end
    end

    assign o_rdy  = w_rdy[0] & ~i_flush;
    assign o_vld  = r_vld[DEPTH-1];
    assign o_data = r_data[DEPTH-1];

`ifdef REG_PIPE_CNT_EN
    logic             r_cnt_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_up;
    logic             w_dn;

    assign w_up = i_vld & o_rdy;
    assign w_dn = o_vld & i_rdy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_cnt_q <= 1'b0;
        end else if (i_flush) begin
            r_cnt   <= '0;
            r_cnt_q <= 1'b0;
        end else begin
            r_cnt_q <= w_up ^ w_dn;
            if (w_up && !w_dn) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dn && !w_up) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_reg_pipe_vld_rdy.sv
// Randomised and directed bench for reg_pipe_vld_rdy (DEPTH=3) against an item/position queue model.
module tb_reg_pipe_vld_rdy;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_vld = 1'b1;
    logic        o_rdy;
    logic [31:0] i_data = 32'hFFFF0000;
    logic        o_vld;
    logic        i_rdy = 1'b0;
    logic [31:0] o_data;
`ifdef REG_PIPE_CNT_EN
    logic [1:0]  o_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_pipe_vld_rdy #(.DATA_WIDTH(32), .DEPTH(D), .RST_VAL(32'h0000_0000)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_vld(i_vld), .o_rdy(o_rdy),
        .i_data(i_data), .o_vld(o_vld), .i_rdy(i_rdy), .o_data(o_data)
`ifdef REG_PIPE_CNT_EN
        , .o_cnt(o_cnt)
`endif
    );

    // Model: queue of in-flight items, oldest first, each tagged with the stage it occupies.
    typedef struct {
        logic [31:0] d;
        int          pos;
    } item_t;
    item_t       mq[$];
    bit          m_adv [0:D];
    logic [31:0] m_last = 32'h0;

    // Decide which items move this edge; returns whether stage 0 can take a new item.
    function automatic bit plan();
        bit r0;
        r0 = 1'b1;
        for (int i = 0; i < mq.size(); i++) begin
            int p;
            p = mq[i].pos;
            if (p == D - 1)                           m_adv[i] = i_rdy;
            else if (i > 0 && mq[i-1].pos == p + 1)   m_adv[i] = m_adv[i-1];
            else                                      m_adv[i] = 1'b1;
            if (p == 0) r0 = m_adv[i];
        end
        return r0;
    endfunction

    always @(posedge i_rst) begin
        mq.delete();
        m_last = 32'h0;
    end

    always @(posedge clk) begin
        if (!i_rst) begin
            if (i_flush) begin
                mq.delete();
            end else begin
                bit r0;
                bit pop;
                r0  = plan();
                pop = 1'b0;
                for (int i = 0; i < mq.size(); i++) begin
                    if (m_adv[i]) begin
                        if (mq[i].pos == D - 1) begin
                            pop = 1'b1;
                        end else begin
                            mq[i].pos = mq[i].pos + 1;
                            if (mq[i].pos == D - 1) m_last = mq[i].d;
                        end
                    end
                end
                if (pop) void'(mq.pop_front());
                if (i_vld && r0) mq.push_back('{d: i_data, pos: 0});
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic er;
        logic ev;
        er = plan() & ~i_flush;
        ev = (mq.size() > 0) && (mq[0].pos == D - 1);
        chk("model_rdy", {31'h0, o_rdy}, {31'h0, er});
        chk("model_vld", {31'h0, o_vld}, {31'h0, ev});
        chk("model_data", o_data, m_last);
`ifdef REG_PIPE_CNT_EN
        chk("model_cnt", 32'(o_cnt), 32'(mq.size()));
`endif
    end

    task automatic tick(input logic v, input logic [31:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        i_vld = v; i_data = d; i_rdy = r; i_flush = f;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a valid input present: nothing may be captured.
        #7;
        chk("rst_vld", {31'h0, o_vld}, 32'h0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_rdy", {31'h0, o_rdy}, 32'h1);
        #14;
        i_vld = 1'b0;
        i_rst = 1'b0;
        tick(0, 32'h0, 1, 0);
        chk("post_rst_vld", {31'h0, o_vld}, 32'h0);

        // Streaming at full rate.
        tick(1, 32'h11, 1, 0); chk("s0_vld", {31'h0, o_vld}, 32'h0);
        tick(1, 32'h22, 1, 0);
        tick(1, 32'h33, 1, 0); chk("s2_vld", {31'h0, o_vld}, 32'h0);
        tick(1, 32'h44, 1, 0); chk("s3_vld", {31'h0, o_vld}, 32'h1); chk("s3_data", o_data, 32'h11);
        tick(0, 32'h0, 1, 0);  chk("s4_data", o_data, 32'h22);
        tick(0, 32'h0, 1, 0);  chk("s5_data", o_data, 32'h33);
        tick(0, 32'h0, 1, 0);  chk("s6_data", o_data, 32'h44); chk("s6_vld", {31'h0, o_vld}, 32'h1);
        tick(0, 32'h0, 1, 0);  chk("s7_vld", {31'h0, o_vld}, 32'h0);

        // Backpressure fills the pipe, then drains in order.
        tick(1, 32'hA1, 0, 0); chk("bp_rdy1", {31'h0, o_rdy}, 32'h1);
        tick(1, 32'hA2, 0, 0); chk("bp_rdy2", {31'h0, o_rdy}, 32'h1);
        tick(1, 32'hA3, 0, 0); chk("bp_rdy3", {31'h0, o_rdy}, 32'h1);
        tick(1, 32'hA4, 0, 0); chk("bp_full", {31'h0, o_rdy}, 32'h0); chk("bp_hold", o_data, 32'hA1);
        tick(1, 32'hA4, 0, 0); chk("bp_full2", {31'h0, o_rdy}, 32'h0); chk("bp_hold2", o_data, 32'hA1);
        tick(1, 32'hA4, 1, 0); chk("bp_release", {31'h0, o_rdy}, 32'h1); chk("bp_d1", o_data, 32'hA1);
        tick(0, 32'h0, 1, 0);  chk("bp_d2", o_data, 32'hA2);
        tick(0, 32'h0, 1, 0);  chk("bp_d3", o_data, 32'hA3);
        tick(0, 32'h0, 1, 0);  chk("bp_d4", o_data, 32'hA4);
        tick(0, 32'h0, 1, 0);  chk("bp_empty", {31'h0, o_vld}, 32'h0);

        // Bubble collapse under a stalled consumer.
        tick(1, 32'hB1, 0, 0);
        tick(0, 32'h0, 0, 0);
        tick(0, 32'h0, 0, 0);
        tick(1, 32'hB2, 0, 0); chk("bc_head", o_data, 32'hB1); chk("bc_vld", {31'h0, o_vld}, 32'h1);
        tick(1, 32'hB3, 0, 0); chk("bc_rdy", {31'h0, o_rdy}, 32'h1);
        tick(0, 32'h0, 0, 0);  chk("bc_full", {31'h0, o_rdy}, 32'h0);
`ifdef REG_PIPE_CNT_EN
        chk("bc_cnt", 32'(o_cnt), 32'd3);
`endif
        tick(0, 32'h0, 1, 0);
        tick(0, 32'h0, 1, 0);
        tick(0, 32'h0, 1, 0);  chk("bc_last", o_data, 32'hB3);

        // Flush a full pipe while a new item is offered.
        tick(0, 32'h0, 1, 0);
        tick(1, 32'hC1, 0, 0);
        tick(1, 32'hC2, 0, 0);
        tick(1, 32'hC3, 0, 0);
        tick(1, 32'hC4, 0, 1); chk("fl_rdy", {31'h0, o_rdy}, 32'h0); chk("fl_head", o_data, 32'hC1);
`ifdef REG_PIPE_CNT_EN
        chk("fl_cnt_pre", 32'(o_cnt), 32'd3);
`endif
        tick(0, 32'h0, 1, 0);  chk("fl_vld", {31'h0, o_vld}, 32'h0); chk("fl_keep", o_data, 32'hC1);
`ifdef REG_PIPE_CNT_EN
        chk("fl_cnt", 32'(o_cnt), 32'd0);
`endif
        tick(0, 32'h0, 1, 0);
        tick(0, 32'h0, 1, 0);  chk("fl_no_c4", {31'h0, o_vld}, 32'h0);

        // Asynchronous reset in the middle of a stream.
        tick(1, 32'h55, 1, 0);
        tick(1, 32'h66, 1, 0);
        tick(1, 32'h77, 1, 0);
        tick(1, 32'h88, 1, 0); chk("ar_pre", o_data, 32'h55);
        @(posedge clk);
        #3 i_rst = 1'b1;
        #1;
        chk("ar_vld", {31'h0, o_vld}, 32'h0);
        chk("ar_data", o_data, 32'h0);
`ifdef REG_PIPE_CNT_EN
        chk("ar_cnt", 32'(o_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        i_vld = 1'b0;
        tick(0, 32'h0, 1, 0);  chk("ar_after", {31'h0, o_vld}, 32'h0);

        // Random traffic checked cycle by cycle against the model.
        for (int n = 0; n < 600; n++) begin
            tick($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 24) == 0);
        end
        for (int n = 0; n < 6; n++) tick(0, 32'h0, 1, 0);
        chk("final_empty", {31'h0, o_vld}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
